msg_sequencer: RTL and testbench

//  Controller that streams a stored ASCII message to a downstream sink one character at a time.

---
 rtl/msg_sequencer_pkg.sv | 53 +++++
 rtl/msg_sequencer_if.sv | 27 ++
 rtl/msg_sequencer_char_rom.sv | 34 +++
 rtl/msg_sequencer.sv | 147 ++++++++++++++
 tb/tb_msg_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_sequencer_pkg.sv
// Shared types and message contents for the message sequencer.
package msg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic {
    MSG_A = 1'b0,
    MSG_B = 1'b1
  } msg_id_t;

  localparam int MSG_A_LEN = 9;
  localparam int MSG_B_LEN = 7;

  // 00/11 select MSG_A, 01/10 select MSG_B
  function automatic msg_id_t sel_to_msg(input logic [1:0] sel);
    return (sel[1] ^ sel[0]) ? MSG_B : MSG_A;
  endfunction

  // "Guatemala"
  function automatic logic [7:0] msg_a_char(input int unsigned i);
    case (i)
      0:       return 8'h47;
      1:       return 8'h75;
      2:       return 8'h61;
      3:       return 8'h74;
      4:       return 8'h65;
      5:       return 8'h6D;
      6:       return 8'h61;
      7:       return 8'h6C;
      8:       return 8'h61;
      default: return 8'h00;
    endcase
  endfunction

  // "Quetzal"
  function automatic logic [7:0] msg_b_char(input int unsigned i);
    case (i)
      0:       return 8'h51;
      1:       return 8'h75;
      2:       return 8'h65;
      3:       return 8'h74;
      4:       return 8'h7A;
      5:       return 8'h61;
      6:       return 8'h6C;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/msg_sequencer_if.sv
// Control and character-bus signals between the sequencer and its environment.
interface msg_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             abort;
  logic [1:0]       msg_sel;
  logic             repeat_en;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             char_ready;
  logic [IDX_W-1:0] char_idx;
  logic             busy;
  logic             done;

  // Sequencer side
  modport master (
    input  start, abort, msg_sel, repeat_en, char_ready,
    output char_out, char_valid, char_idx, busy, done
  );

  // Controller / sink side
  modport slave (
    output start, abort, msg_sel, repeat_en, char_ready,
    input  char_out, char_valid, char_idx, busy, done
  );
endinterface

// File: rtl/msg_sequencer_char_rom.sv
// Combinational message ROM: (message, index) -> (character, message length).
module msg_char_rom
  import msg_seq_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int LEN_W = 4
) (
  input  msg_id_t          sel_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       char_o,
  output logic [LEN_W-1:0] len_o
);

  // Look up the character and the length of the selected message
  always_comb begin
    char_o = 8'h00;
    len_o  = '0;
    case (sel_i)
      MSG_A: begin
        char_o = msg_a_char(32'(idx_i));
        len_o  = LEN_W'(MSG_A_LEN);
      end
      MSG_B: begin
        char_o = msg_b_char(32'(idx_i));
        len_o  = LEN_W'(MSG_B_LEN);
      end
      default: begin
        char_o = 8'h00;
        len_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/msg_sequencer.sv
// Streams a stored ASCII message one character per handshake, with optional
// repeat separated by an idle gap. All outputs are registered.
module msg_sequencer
  import msg_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int IDX_W      = 4,
  parameter int MAX_LEN    = 9
) (
  input  logic             clk,
  input  logic             reset,
  msg_sequencer_if.master  bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  // Gap counter runs 0..GAP_CYCLES-1, so it never needs to hold GAP_CYCLES itself
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q;
  msg_id_t          sel_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       char_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [GAP_W-1:0] gap_q;

  msg_id_t          rom_sel_d;
  logic [IDX_W-1:0] rom_idx_d;
  logic [7:0]       rom_char;
  logic [LEN_W-1:0] rom_len;
  logic             xfer;
  logic             last_char;

  // ROM address points at whatever character gets loaded on the next edge:
  // the newly selected message's char 0 from IDLE, the following char after a
  // mid-message handshake, and char 0 of the latched message otherwise.
  always_comb begin
    xfer      = valid_q & bus.char_ready;
    last_char = (32'(idx_q) + 32'd1 == 32'(len_q));
    rom_sel_d = (state_q == ST_IDLE) ? sel_to_msg(bus.msg_sel) : sel_q;
    rom_idx_d = (state_q == ST_SEND && !last_char) ? idx_q + 1'b1 : '0;
  end

  msg_char_rom #(
    .IDX_W (IDX_W),
    .LEN_W (LEN_W)
  ) u_rom (
    .sel_i  (rom_sel_d),
    .idx_i  (rom_idx_d),
    .char_o (rom_char),
    .len_o  (rom_len)
  );

  // Sequencer FSM with index and gap counters; char_q only changes when a new
  // character is loaded so it holds its last value while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= MSG_A;
      len_q   <= '0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            sel_q   <= rom_sel_d;
            len_q   <= rom_len;
            idx_q   <= '0;
            char_q  <= rom_char;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (bus.abort) begin
            // A handshake in this same cycle still completes, but no done follows
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (xfer) begin
            if (!last_char) begin
              idx_q  <= idx_q + 1'b1;
              char_q <= rom_char;
            end else begin
              done_q <= 1'b1;
              idx_q  <= '0;
              if (bus.repeat_en) begin
                if (GAP_CYCLES == 0) begin
                  char_q <= rom_char;
                end else begin
                  gap_q   <= '0;
                  valid_q <= 1'b0;
                  state_q <= ST_GAP;
                end
              end else begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
        end

        ST_GAP: begin
          if (bus.abort) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (gap_q == GAP_LAST) begin
            idx_q   <= '0;
            char_q  <= rom_char;
            valid_q <= 1'b1;
            state_q <= ST_SEND;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          idx_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.char_idx   = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// Scoreboard bench for msg_sequencer: expected characters are queued when a
// message is started and checked on every observed handshake.
module tb_msg_sequencer;

  localparam int IDX_W = 4;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  msg_sequencer_if #(.IDX_W(IDX_W)) bus ();

  msg_sequencer #(
    .GAP_CYCLES (GAP),
    .IDX_W      (IDX_W),
    .MAX_LEN    (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  string       txt_a = "Guatemala";
  string       txt_b = "Quetzal";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chars(input string s, input int first, input int last);
    for (int i = first; i <= last; i++)
      exp_q.push_back({4'(i), 8'(s[i])});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  // Every handshake seen on the bus must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.char_valid === 1'b1 && bus.char_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'({bus.char_idx, bus.char_out}), 32'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer", 32'({bus.char_idx, bus.char_out}), 32'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic        stall;
    logic [7:0]  pc;
    logic [IDX_W-1:0] pi;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.msg_sel    = 2'b00;
    bus.repeat_en  = 1'b0;
    bus.char_ready = 1'b0;
    tick();
    tick();
    chk("rst_char",  32'(bus.char_out),   32'h00);
    chk("rst_valid", 32'(bus.char_valid), 32'd0);
    chk("rst_idx",   32'(bus.char_idx),   32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_done",  32'(bus.done),       32'd0);
    reset = 1'b0;
    tick();

    // 1: MSG_A at full throughput
    bus.msg_sel    = 2'b00;
    bus.char_ready = 1'b1;
    bus.start      = 1'b1;
    push_chars(txt_a, 0, 8);
    tick();
    bus.start = 1'b0;
    chk("t1_latency_valid", 32'(bus.char_valid), 32'd1);
    chk("t1_first_idx",     32'(bus.char_idx),   32'd0);
    for (int k = 0; k < 9; k++) begin
      chk("t1_valid_run", 32'(bus.char_valid), 32'd1);
      chk("t1_done_early", 32'(bus.done), 32'd0);
      tick();
    end
    chk("t1_done",  32'(bus.done),       32'd1);
    chk("t1_valid", 32'(bus.char_valid), 32'd0);
    chk("t1_busy",  32'(bus.busy),       32'd0);
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);

    // 2: MSG_B with ready toggling, char held while stalled
    bus.msg_sel    = 2'b01;
    bus.char_ready = 1'b0;
    bus.start      = 1'b1;
    push_chars(txt_b, 0, 6);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      stall = bus.char_valid & ~bus.char_ready;
      pc    = bus.char_out;
      pi    = bus.char_idx;
      tick();
      if (stall) begin
        chk("t2_hold_char", 32'(bus.char_out), 32'(pc));
        chk("t2_hold_idx",  32'(bus.char_idx), 32'(pi));
      end
      bus.char_ready = ~bus.char_ready;
      n++;
    end
    chk("t2_done_seen", 32'(bus.done), 32'd1);
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);
    bus.char_ready = 1'b1;
    tick();

    // 3: repeat with gap, msg_sel changed mid-message
    bus.msg_sel   = 2'b10;
    bus.repeat_en = 1'b1;
    bus.start     = 1'b1;
    push_chars(txt_b, 0, 6);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.msg_sel = 2'b00;
    wait_done("t3a");
    push_chars(txt_b, 0, 6);
    bus.repeat_en = 1'b0;
    n = 0;
    while (!bus.char_valid && n < 20) begin
      n++;
      tick();
    end
    chk("t3_gap_cycles", 32'(n), 32'(GAP));
    chk("t3_resend_idx", 32'(bus.char_idx), 32'd0);
    chk("t3_resend_char", 32'(bus.char_out), 32'h51);
    wait_done("t3b");
    chk("t3_busy_end", 32'(bus.busy), 32'd0);
    tick();

    // 4: abort at idx 3, then a fresh start
    bus.msg_sel = 2'b00;
    bus.start   = 1'b1;
    push_chars(txt_a, 0, 3);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.char_idx != 4'd3 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_reach_idx3", 32'(bus.char_idx), 32'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4_valid", 32'(bus.char_valid), 32'd0);
    chk("t4_busy",  32'(bus.busy),       32'd0);
    chk("t4_idx",   32'(bus.char_idx),   32'd0);
    chk("t4_done",  32'(bus.done),       32'd0);
    tick();
    chk("t4_done_later", 32'(bus.done), 32'd0);
    bus.msg_sel = 2'b01;
    bus.start   = 1'b1;
    push_chars(txt_b, 0, 6);
    tick();
    bus.start = 1'b0;
    chk("t4_restart_idx", 32'(bus.char_idx), 32'd0);
    chk("t4_restart_char", 32'(bus.char_out), 32'h51);

    // 5: start while busy is ignored
    tick();
    tick();
    bus.msg_sel = 2'b00;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("t5_busy_start");
    tick();
    chk("t5_idle_after", 32'(bus.busy), 32'd0);

    // 5: start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t5_sa_busy",  32'(bus.busy),       32'd0);
    chk("t5_sa_valid", 32'(bus.char_valid), 32'd0);

    // 5: reset mid-SEND
    bus.msg_sel = 2'b00;
    bus.start   = 1'b1;
    push_chars(txt_a, 0, 2);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t5_rst_char",  32'(bus.char_out),   32'h00);
    chk("t5_rst_valid", 32'(bus.char_valid), 32'd0);
    chk("t5_rst_idx",   32'(bus.char_idx),   32'd0);
    chk("t5_rst_busy",  32'(bus.busy),       32'd0);
    chk("t5_rst_done",  32'(bus.done),       32'd0);
    reset = 1'b0;
    tick();

    // 6: abort coincident with the final handshake
    bus.msg_sel = 2'b11;
    bus.start   = 1'b1;
    push_chars(txt_a, 0, 8);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.char_idx != 4'd8 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_reach_last", 32'(bus.char_idx), 32'd8);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t6_no_done", 32'(bus.done),       32'd0);
    chk("t6_busy",    32'(bus.busy),       32'd0);
    chk("t6_valid",   32'(bus.char_valid), 32'd0);
    tick();
    chk("t6_no_done_later", 32'(bus.done), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
